// File: rtl/ex_muldiv.sv
// Iterative multiply/divide unit for the EX stage: radix-2 shift-add multiply and
// restoring divide, one step per cycle, with operand forwarding and HI/LO write-back.
module ex_muldiv #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  valid_in,
  input  logic [2:0]            MdOp,
  input  logic [DATA_WIDTH-1:0] rdata_1,
  input  logic [DATA_WIDTH-1:0] rdata_2,
  input  logic [DATA_WIDTH-1:0] data_out_MEM,
  input  logic [DATA_WIDTH-1:0] data_out_WB,
  input  logic [1:0]            FWA,
  input  logic [1:0]            FWB,
  input  logic [DATA_WIDTH-1:0] hi,
  input  logic [DATA_WIDTH-1:0] lo,
  input  logic [DATA_WIDTH-1:0] hi_MEM,
  input  logic [DATA_WIDTH-1:0] hi_WB,
  input  logic [DATA_WIDTH-1:0] lo_MEM,
  input  logic [DATA_WIDTH-1:0] lo_WB,
  input  logic [1:0]            FWhi,
  input  logic [1:0]            FWlo,
  input  logic [ADDR_WIDTH-1:0] target_in,
  output logic [ADDR_WIDTH-1:0] target_EX,
  output logic                  stall_req,
  output logic                  we_hi,
  output logic                  we_lo,
  output logic [DATA_WIDTH-1:0] hi_EX,
  output logic [DATA_WIDTH-1:0] lo_EX,
  output logic                  div_by_zero
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [W-1:0] fwd_sel(input logic [1:0] sel, input logic [W-1:0] rf,
                                           input logic [W-1:0] mem, input logic [W-1:0] wb);
    case (sel)
      2'b01:   return mem;
      2'b10:   return wb;
      default: return rf;
    endcase
  endfunction

  function automatic logic [W-1:0] magnitude(input logic [W-1:0] v, input logic neg);
    return neg ? ({W{1'b0}} - v) : v;
  endfunction

  state_t        state_r, next_state_s;
  logic [W-1:0]  op_a_s, op_b_s, hi_in_s, lo_in_s, mag_a_s, mag_b_s;
  logic          is_mul_s, is_div_s, signed_s, sign_a_s, sign_b_s, b_zero_s, start_s;
  logic [W-1:0]  a_r, b_r, a_raw_r, acc_r, lo_r;
  logic [CW-1:0] cnt_r;
  logic          sign_a_r, sign_b_r, is_div_r, dbz_r;
  logic [W:0]    sum_s, rem_sh_s, diff_s;
  logic [W-1:0]  step_acc_s, step_lo_s, quo_s, rem_s;
  logic [2*W-1:0] prod_s, prod_res_s;

  assign target_EX = target_in;

  // Operand forwarding and opcode decode
  always_comb begin
    op_a_s   = fwd_sel(FWA, rdata_1, data_out_MEM, data_out_WB);
    op_b_s   = fwd_sel(FWB, rdata_2, data_out_MEM, data_out_WB);
    hi_in_s  = fwd_sel(FWhi, hi, hi_MEM, hi_WB);
    lo_in_s  = fwd_sel(FWlo, lo, lo_MEM, lo_WB);
    is_mul_s = 1'b0;
    is_div_s = 1'b0;
    signed_s = 1'b0;
    case (MdOp)
      3'b001: begin is_mul_s = 1'b1; signed_s = 1'b1; end
      3'b010: begin is_mul_s = 1'b1; end
      3'b011: begin is_div_s = 1'b1; signed_s = 1'b1; end
      3'b100: begin is_div_s = 1'b1; end
      default: begin is_mul_s = 1'b0; end
    endcase
    sign_a_s = signed_s & op_a_s[W-1];
    sign_b_s = signed_s & op_b_s[W-1];
    mag_a_s  = magnitude(op_a_s, sign_a_s);
    mag_b_s  = magnitude(op_b_s, sign_b_s);
    b_zero_s = (op_b_s == {W{1'b0}});
    start_s  = (state_r == IDLE) & valid_in & (is_mul_s | is_div_s) & ~flush;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= next_state_s;
  end

  // Next-state logic; flush overrides everything
  always_comb begin
    next_state_s = state_r;
    if (flush) begin
      next_state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (!start_s)      next_state_s = IDLE;
          else if (is_mul_s) next_state_s = MUL;
          else if (b_zero_s) next_state_s = DONE;
          else               next_state_s = DIV;
        end
        MUL, DIV: begin
          if (cnt_r == CNT_ONE) next_state_s = DONE;
          else                  next_state_s = state_r;
        end
        DONE:    next_state_s = IDLE;
        default: next_state_s = IDLE;
      endcase
    end
  end

  // One iteration step: acc holds the running high half / partial remainder,
  // lo holds the multiplier being shifted out / quotient being shifted in
  always_comb begin
    sum_s      = {1'b0, acc_r} + (lo_r[0] ? {1'b0, a_r} : {(W+1){1'b0}});
    rem_sh_s   = {acc_r, lo_r[W-1]};
    diff_s     = rem_sh_s - {1'b0, b_r};
    step_acc_s = acc_r;
    step_lo_s  = lo_r;
    case (state_r)
      MUL: begin
        step_acc_s = sum_s[W:1];
        step_lo_s  = {sum_s[0], lo_r[W-1:1]};
      end
      DIV: begin
        if (diff_s[W]) begin
          step_acc_s = rem_sh_s[W-1:0];
          step_lo_s  = {lo_r[W-2:0], 1'b0};
        end else begin
          step_acc_s = diff_s[W-1:0];
          step_lo_s  = {lo_r[W-2:0], 1'b1};
        end
      end
      default: begin
        step_acc_s = acc_r;
        step_lo_s  = lo_r;
      end
    endcase
  end

  // Operand latch on start, iterate while busy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r      <= {W{1'b0}};
      b_r      <= {W{1'b0}};
      a_raw_r  <= {W{1'b0}};
      acc_r    <= {W{1'b0}};
      lo_r     <= {W{1'b0}};
      cnt_r    <= {CW{1'b0}};
      sign_a_r <= 1'b0;
      sign_b_r <= 1'b0;
      is_div_r <= 1'b0;
      dbz_r    <= 1'b0;
    end else if (start_s) begin
      a_r      <= mag_a_s;
      b_r      <= mag_b_s;
      a_raw_r  <= op_a_s;
      acc_r    <= {W{1'b0}};
      lo_r     <= is_div_s ? mag_a_s : mag_b_s;
      cnt_r    <= CNT_LOAD;
      sign_a_r <= sign_a_s;
      sign_b_r <= sign_b_s;
      is_div_r <= is_div_s;
      dbz_r    <= is_div_s & b_zero_s;
    end else if ((state_r == MUL) || (state_r == DIV)) begin
      acc_r <= step_acc_s;
      lo_r  <= step_lo_s;
      cnt_r <= cnt_r - CNT_ONE;
    end
  end

  // Outputs: result and write enables only in DONE, forwarded HI/LO otherwise
  always_comb begin
    prod_s     = {acc_r, lo_r};
    prod_res_s = (sign_a_r ^ sign_b_r) ? ({(2*W){1'b0}} - prod_s) : prod_s;
    quo_s      = (sign_a_r ^ sign_b_r) ? ({W{1'b0}} - lo_r) : lo_r;
    rem_s      = sign_a_r ? ({W{1'b0}} - acc_r) : acc_r;
    case (state_r)
      IDLE:     stall_req = start_s;
      MUL, DIV: stall_req = 1'b1;
      default:  stall_req = 1'b0;
    endcase
    we_hi       = 1'b0;
    we_lo       = 1'b0;
    div_by_zero = 1'b0;
    hi_EX       = hi_in_s;
    lo_EX       = lo_in_s;
    if (state_r == DONE) begin
      we_hi = 1'b1;
      we_lo = 1'b1;
      if (dbz_r) begin
        div_by_zero = 1'b1;
        hi_EX       = a_raw_r;
        lo_EX       = {W{1'b1}};
      end else if (is_div_r) begin
        hi_EX = rem_s;
        lo_EX = quo_s;
      end else begin
        hi_EX = prod_res_s[2*W-1:W];
        lo_EX = prod_res_s[W-1:0];
      end
    end else begin
      hi_EX = hi_in_s;
      lo_EX = lo_in_s;
    end
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Randomized scoreboard bench for ex_muldiv: stimulus pushes expected HI/LO results,
// a negedge monitor pops them on every write and checks forwarding otherwise.
module tb_ex_muldiv;

  logic        clk = 1'b0;
  logic        rst, flush, valid_in;
  logic [2:0]  MdOp;
  logic [31:0] rdata_1, rdata_2, data_out_MEM, data_out_WB;
  logic [1:0]  FWA, FWB, FWhi, FWlo;
  logic [31:0] hi, lo, hi_MEM, hi_WB, lo_MEM, lo_WB;
  logic [4:0]  target_in, target_EX;
  logic        stall_req, we_hi, we_lo, div_by_zero;
  logic [31:0] hi_EX, lo_EX;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  ex_muldiv #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_in(valid_in), .MdOp(MdOp),
    .rdata_1(rdata_1), .rdata_2(rdata_2), .data_out_MEM(data_out_MEM),
    .data_out_WB(data_out_WB), .FWA(FWA), .FWB(FWB), .hi(hi), .lo(lo),
    .hi_MEM(hi_MEM), .hi_WB(hi_WB), .lo_MEM(lo_MEM), .lo_WB(lo_WB),
    .FWhi(FWhi), .FWlo(FWlo), .target_in(target_in), .target_EX(target_EX),
    .stall_req(stall_req), .we_hi(we_hi), .we_lo(we_lo), .hi_EX(hi_EX),
    .lo_EX(lo_EX), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [1:0] s, input logic [31:0] r,
                                      input logic [31:0] m, input logic [31:0] w);
    case (s)
      2'b01:   return m;
      2'b10:   return w;
      default: return r;
    endcase
  endfunction

  function automatic logic [31:0] rnd_val();
    case ($urandom % 6)
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom % 16);
      default: return 32'($urandom);
    endcase
  endfunction

  // Reference behaviour from plain wide arithmetic
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output exp_t e);
    logic signed [63:0] sa, sb, sq, sr;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    e.dbz = 1'b0;
    e.hi  = 32'h0;
    e.lo  = 32'h0;
    if ((op == 3'd3 || op == 3'd4) && b == 32'h0) begin
      e.hi  = a;
      e.lo  = 32'hFFFF_FFFF;
      e.dbz = 1'b1;
    end else begin
      case (op)
        3'd1: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
        3'd2: begin p = {32'h0, a} * {32'h0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
        3'd3: begin sq = sa / sb; sr = sa % sb; e.hi = sr[31:0]; e.lo = sq[31:0]; end
        3'd4: begin e.hi = a % b; e.lo = a / b; end
        default: e.dbz = 1'b0;
      endcase
    end
  endtask

  task automatic scramble_side();
    hi = $urandom; lo = $urandom; hi_MEM = $urandom; hi_WB = $urandom;
    lo_MEM = $urandom; lo_WB = $urandom;
    FWhi = 2'($urandom); FWlo = 2'($urandom); target_in = 5'($urandom);
  endtask

  task automatic scramble_ops();
    valid_in = 1'($urandom); MdOp = 3'($urandom);
    rdata_1 = $urandom; rdata_2 = $urandom; data_out_MEM = $urandom; data_out_WB = $urandom;
    FWA = 2'($urandom); FWB = 2'($urandom);
  endtask

  // Drive one instruction from the current operand inputs and measure its stall length
  task automatic issue(input logic [2:0] op, input logic v);
    logic [31:0] a, b;
    exp_t e;
    int cnt, exp_stall;
    bit go;
    a = fwd(FWA, rdata_1, data_out_MEM, data_out_WB);
    b = fwd(FWB, rdata_2, data_out_MEM, data_out_WB);
    MdOp = op;
    valid_in = v;
    go = v && (op >= 3'd1) && (op <= 3'd4);
    exp_stall = 0;
    if (go) begin
      model(op, a, b, e);
      sb_q.push_back(e);
      exp_stall = ((op == 3'd3 || op == 3'd4) && b == 32'h0) ? 1 : 33;
    end
    cnt = 0;
    @(negedge clk);
    if (stall_req) cnt++;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      scramble_side();
      if (go) scramble_ops();
      @(negedge clk);
      if (!stall_req) break;
      cnt++;
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    MdOp = 3'd0;
    chk("stall_cycles", 64'(cnt), 64'(exp_stall));
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    exp_t e;
    chk("target_EX", 64'(target_EX), 64'(target_in));
    if (we_hi || we_lo) begin
      chk("we_pair", 64'(we_hi), 64'(we_lo));
      if (sb_q.size() == 0) begin
        chk("unexpected_write", 64'(1), 64'(0));
      end else begin
        e = sb_q.pop_front();
        chk("hi_EX", 64'(hi_EX), 64'(e.hi));
        chk("lo_EX", 64'(lo_EX), 64'(e.lo));
        chk("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
      end
    end else begin
      chk("hi_fwd", 64'(hi_EX), 64'(fwd(FWhi, hi, hi_MEM, hi_WB)));
      chk("lo_fwd", 64'(lo_EX), 64'(fwd(FWlo, lo, lo_MEM, lo_WB)));
      chk("dbz_idle", 64'(div_by_zero), 64'(0));
    end
  end

  task automatic set_ops(input logic [31:0] a, input logic [31:0] b);
    FWA = 2'b00; FWB = 2'b00; rdata_1 = a; rdata_2 = b;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; valid_in = 1'b0; MdOp = 3'd0;
    rdata_1 = 32'h0; rdata_2 = 32'h0; data_out_MEM = 32'h0; data_out_WB = 32'h0;
    FWA = 2'b00; FWB = 2'b00;
    scramble_side();
    repeat (2) @(negedge clk);
    chk("rst_stall", 64'(stall_req), 64'(0));
    chk("rst_we", 64'({we_hi, we_lo}), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;

    set_ops(32'hFFFF_FFFE, 32'h3);            issue(3'd1, 1'b1);
    set_ops(32'hFFFF_FFFF, 32'hFFFF_FFFF);    issue(3'd2, 1'b1);
    set_ops(32'hFFFF_FFF9, 32'h2);            issue(3'd3, 1'b1);
    set_ops(32'h8000_0000, 32'hFFFF_FFFF);    issue(3'd3, 1'b1);
    set_ops(32'd100, 32'h0);                  issue(3'd4, 1'b1);
    set_ops(32'd5, 32'd9);                    issue(3'd6, 1'b1);

    rdata_1 = $urandom; rdata_2 = $urandom;
    FWA = 2'b01; data_out_MEM = 32'd6; FWB = 2'b10; data_out_WB = 32'd7;
    issue(3'd2, 1'b1);

    // Flush after ten multiply steps: no write may follow
    set_ops(32'd1234, 32'd5678);
    MdOp = 3'd2; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0; MdOp = 3'd0;
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    chk("flush_stall", 64'(stall_req), 64'(0));
    repeat (3) @(negedge clk);

    // Flush during DONE still lets that cycle's write through
    begin
      exp_t e;
      set_ops(32'd9, 32'd11);
      model(3'd2, 32'd9, 32'd11, e);
      sb_q.push_back(e);
      MdOp = 3'd2; valid_in = 1'b1;
      @(posedge clk); #1;
      valid_in = 1'b0; MdOp = 3'd0;
      repeat (32) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      chk("done_flush_we", 64'(we_hi), 64'(1));
      @(posedge clk); #1;
      flush = 1'b0;
      @(negedge clk);
      chk("done_flush_idle", 64'(stall_req), 64'(0));
    end

    // Reset in the middle of a divide
    set_ops(32'd1000, 32'd7);
    MdOp = 3'd4; valid_in = 1'b1;
    @(posedge clk); #1;
    valid_in = 1'b0; MdOp = 3'd0;
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("rst_mid_stall", 64'(stall_req), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    set_ops(32'd3, 32'd4);                    issue(3'd2, 1'b1);

    for (int n = 0; n < 50; n++) begin
      logic [2:0] op;
      rdata_1 = rnd_val(); rdata_2 = rnd_val();
      data_out_MEM = rnd_val(); data_out_WB = rnd_val();
      FWA = 2'($urandom); FWB = 2'($urandom);
      op = ($urandom % 10 < 8) ? 3'(1 + $urandom % 4) : 3'($urandom);
      issue(op, ($urandom % 8) != 0);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 Parameter DATA_WIDTH, default 32, operand/result width; SHALL be even and >= 8.
REQ-002 Parameter ADDR_WIDTH, default 5, register address width; used only in port widths.
REQ-003 Ports SHALL be, in order:
  clk  in  1  single clock, rising edge
  rst  in  1  asynchronous, active-high reset
  flush  in  1  abort current operation
  valid_in  in  1  instruction in EX is valid
  MdOp  in  3  000 none, 001 MULT, 010 MULTU, 011 DIV, 100 DIVU; others treated as none
  rdata_1, rdata_2  in  DATA_WIDTH  register-file operands
  data_out_MEM, data_out_WB  in  DATA_WIDTH  forwarded GPR data
  FWA, FWB  in  2  forward select: 00 rdata, 01 MEM, 10 WB, 11 rdata
  hi, lo  in  DATA_WIDTH  current HI/LO
  hi_MEM, hi_WB, lo_MEM, lo_WB  in  DATA_WIDTH  forwarded HI/LO
  FWhi, FWlo  in  2  same encoding as FWA
  target_in  in  ADDR_WIDTH  passed through unchanged to target_EX
  target_EX  out  ADDR_WIDTH  = target_in
  stall_req  out  1  hold IF/ID/EX this cycle
  we_hi, we_lo  out  1  HI/LO write enable
  hi_EX, lo_EX  out  DATA_WIDTH  HI/LO value to MEM stage
  div_by_zero  out  1  one-cycle flag with a DIV/DIVU result

Function
REQ-004 Operands A/B and hi_in/lo_in SHALL be selected combinationally by FWA/FWB/FWhi/FWlo.
REQ-005 FSM states SHALL be IDLE, MUL, DIV, DONE; start = IDLE & valid_in & MdOp in {001..100} & ~flush.
REQ-006 On start, A and B SHALL be latched; signed ops latch magnitudes plus sign bits; cycle counter loads DATA_WIDTH.
REQ-007 IDLE -> MUL on MULT/MULTU start; IDLE -> DIV on DIV/DIVU start with B != 0; IDLE -> DONE on DIV/DIVU start with B == 0.
REQ-008 MUL SHALL perform one radix-2 shift-add step per cycle; DIV one restoring shift-subtract step per cycle; after DATA_WIDTH steps -> DONE.
REQ-009 DONE SHALL last exactly one cycle then -> IDLE; new start is not accepted in DONE.
REQ-010 stall_req SHALL be 1 when (IDLE & start) or state is MUL or DIV; 0 in DONE and idle IDLE; a multiply/divide stalls exactly DATA_WIDTH+1 cycles.
REQ-011 In DONE, we_hi = we_lo = 1; otherwise both 0.
REQ-012 MULT/MULTU: {hi_EX, lo_EX} = full 2*DATA_WIDTH product; MULT negates the product when operand signs differ.
REQ-013 DIV/DIVU: lo_EX = quotient, hi_EX = remainder; DIV quotient negated when signs differ, remainder takes dividend sign.
REQ-014 DIV of most-negative by -1 SHALL give lo_EX = most-negative (wraps), hi_EX = 0, no flag.
REQ-015 Divide by zero: hi_EX = latched dividend (as forwarded), lo_EX = all ones, div_by_zero = 1 in DONE; total stall 1 cycle.
REQ-016 Outside DONE, hi_EX = hi_in and lo_EX = lo_in (forwarded values), div_by_zero = 0.
REQ-017 flush SHALL force next state IDLE from any state, with no write-enable in the following cycle; flush in DONE does not suppress that cycle's write.
REQ-018 valid_in and MdOp changes while not IDLE SHALL be ignored; operands are not re-sampled.

Reset
REQ-019 rst SHALL asynchronously force IDLE, counter 0, internal operand/accumulator registers 0.
REQ-020 During and after reset until a start: stall_req = 0, we_hi = we_lo = 0, div_by_zero = 0, hi_EX/lo_EX = forwarded hi_in/lo_in.
REQ-021 Reset asserted mid-operation SHALL discard the operation; no HI/LO write occurs.

Verification (DATA_WIDTH = 32)
REQ-022 MULT A=0xFFFFFFFE (-2), B=3 -> stall 33 cycles, then DONE: hi_EX=0xFFFFFFFF, lo_EX=0xFFFFFFFA, we_hi=we_lo=1.
REQ-023 MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> hi_EX=0xFFFFFFFE, lo_EX=0x00000001.
REQ-024 DIV A=-7, B=2 -> lo_EX=0xFFFFFFFD (-3), hi_EX=0xFFFFFFFF (-1); DIV 0x80000000 / -1 -> lo_EX=0x80000000, hi_EX=0.
REQ-025 DIVU A=100, B=0 -> one stall cycle, DONE next: div_by_zero=1, hi_EX=100, lo_EX=0xFFFFFFFF.
REQ-026 FWA=01, data_out_MEM=6, FWB=10, data_out_WB=7, MULTU -> lo_EX=42; flush at step 10 -> IDLE, no we_hi/we_lo.
REQ-027 rst pulsed at step 5 of DIVU -> stall_req drops immediately, no write; a following MULTU 3*4 completes with lo_EX=12.
